// File: rtl/rstseq_pkg.sv
// Shared types and constants for the board reset sequencer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for the raw reset button pin.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic RELEASED_LEVEL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic pressed_q, pressed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic syncPressed;

  assign syncPressed = sync2_q ^ RELEASED_LEVEL;

  // The counter stops at CNT_LAST because the level flips there, so it never wraps.
  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = '0;
    if (syncPressed != pressed_q) begin
      if (cnt_q == CNT_LAST) begin
        pressed_d = syncPressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= RELEASED_LEVEL;
      sync2_q   <= RELEASED_LEVEL;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: peripherals leave reset STAGE_GAP cycles before the CPU.
// Define RSTSEQ_SWREQ_EN to honour sw_reset_req; otherwise that port has no loads.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       sw_reset_req,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic [1:0] reset_cause,
  output logic       seq_busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             periph_q;
  logic             cpu_q;
  logic [1:0]       cause_q;
  logic             busy_q;
  logic             btnPressed;
  logic             swAccept;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .clock  (clock),
    .reset  (reset),
    .btn_in (btn_in),
    .pressed(btnPressed)
  );

`ifdef RSTSEQ_SWREQ_EN
  assign swAccept = sw_reset_req && (state_q == RUN);
`else
  logic unusedSwReq;
  assign unusedSwReq = sw_reset_req;
  assign swAccept    = 1'b0;
`endif

  // Button outranks the software request when both arrive in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      cause_q  <= CAUSE_POR;
      busy_q   <= 1'b1;
    end else if (btnPressed) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      cause_q  <= CAUSE_BTN;
      busy_q   <= 1'b1;
    end else if (swAccept) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      cause_q  <= CAUSE_SW;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            state_q  <= REL_PERIPH;
            cnt_q    <= '0;
            periph_q <= 1'b0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REL_PERIPH: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            cpu_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        default: begin
          state_q  <= ASSERT;
          cnt_q    <= '0;
          periph_q <= 1'b1;
          cpu_q    <= 1'b1;
          busy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign periph_reset = periph_q;
  assign cpu_reset    = cpu_q;
  assign reset_cause  = cause_q;
  assign seq_busy     = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scenario bench for reset_sequencer with DEBOUNCE=8, HOLD=16, GAP=4.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       btn_in;
  logic       sw_reset_req;
  logic       periph_reset;
  logic       cpu_reset;
  logic [1:0] reset_cause;
  logic       seq_busy;

  int testsRun;
  int testsFailed;
  logic [1:0] expCause;
  logic expPeriph, expCpu, expBusy;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (16),
    .STAGE_GAP      (4),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_in      (btn_in),
    .sw_reset_req(sw_reset_req),
    .periph_reset(periph_reset),
    .cpu_reset   (cpu_reset),
    .reset_cause (reset_cause),
    .seq_busy    (seq_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic stepEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_in = 1'b1; sw_reset_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if ({periph_reset, cpu_reset, reset_cause, seq_busy} !== 5'b11001) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_state: got %b expected 11001", {periph_reset, cpu_reset, reset_cause, seq_busy});
    end
    repeat (5) stepEdge();
    reset = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      stepEdge();
      expPeriph = (e < 16);
      expCpu    = (e < 20);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expCpu || seq_busy !== expCpu) begin
        testsFailed++;
        $display("[TB] FAIL por_release edge %0d: got p=%b c=%b b=%b expected p=%b c=%b b=%b",
                 e, periph_reset, cpu_reset, seq_busy, expPeriph, expCpu, expCpu);
      end
    end
    testsRun++;
    if (reset_cause !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL por_cause: got %b expected 00", reset_cause);
    end
    expCause = 2'b00;
  endtask

  task automatic test_glitch();
    btn_in = 1'b0;
    repeat (5) stepEdge();
    btn_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      stepEdge();
      testsRun++;
      if (periph_reset !== 1'b0 || cpu_reset !== 1'b0 || reset_cause !== expCause) begin
        testsFailed++;
        $display("[TB] FAIL glitch_reject edge %0d: got p=%b c=%b cause=%b expected p=0 c=0 cause=%b",
                 e, periph_reset, cpu_reset, reset_cause, expCause);
      end
    end
  endtask

  task automatic test_button_press();
    btn_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      stepEdge();
      expPeriph = (e >= 11);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expPeriph) begin
        testsFailed++;
        $display("[TB] FAIL btn_press edge %0d: got p=%b c=%b expected p=%b c=%b",
                 e, periph_reset, cpu_reset, expPeriph, expPeriph);
      end
      if (e == 11) begin
        testsRun++;
        if (reset_cause !== 2'b01) begin
          testsFailed++;
          $display("[TB] FAIL btn_cause: got %b expected 01", reset_cause);
        end
      end
    end
    btn_in = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      stepEdge();
      expPeriph = (e < 26);
      expCpu    = (e < 30);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expCpu) begin
        testsFailed++;
        $display("[TB] FAIL btn_release edge %0d: got p=%b c=%b expected p=%b c=%b",
                 e, periph_reset, cpu_reset, expPeriph, expCpu);
      end
    end
    expCause = 2'b01;
  endtask

  task automatic test_sw_reset();
    sw_reset_req = 1'b1;
    stepEdge();
    sw_reset_req = 1'b0;
`ifdef RSTSEQ_SWREQ_EN
    testsRun++;
    if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || reset_cause !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL sw_reset_entry: got p=%b c=%b cause=%b expected p=1 c=1 cause=10",
               periph_reset, cpu_reset, reset_cause);
    end
    expCause = 2'b10;
    for (int e = 2; e <= 22; e++) begin
      stepEdge();
      expPeriph = (e < 17);
      expCpu    = (e < 21);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expCpu || reset_cause !== expCause) begin
        testsFailed++;
        $display("[TB] FAIL sw_sequence edge %0d: got p=%b c=%b cause=%b expected p=%b c=%b cause=%b",
                 e, periph_reset, cpu_reset, reset_cause, expPeriph, expCpu, expCause);
      end
      sw_reset_req = (e == 18);
    end
    sw_reset_req = 1'b0;
`else
    for (int e = 1; e <= 6; e++) begin
      testsRun++;
      if (periph_reset !== 1'b0 || cpu_reset !== 1'b0 || reset_cause !== expCause) begin
        testsFailed++;
        $display("[TB] FAIL sw_ignored edge %0d: got p=%b c=%b cause=%b expected p=0 c=0 cause=%b",
                 e, periph_reset, cpu_reset, reset_cause, expCause);
      end
      stepEdge();
    end
`endif
  endtask

  task automatic test_simultaneous();
    btn_in = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      stepEdge();
      if (e == 10) begin
        testsRun++;
        if (periph_reset !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL simul_pre: got p=%b expected p=0", periph_reset);
        end
        sw_reset_req = 1'b1;
      end
    end
    sw_reset_req = 1'b0;
    btn_in = 1'b1;
    testsRun++;
    if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || reset_cause !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL simul_cause: got p=%b c=%b cause=%b expected p=1 c=1 cause=01",
               periph_reset, cpu_reset, reset_cause);
    end
    expCause = 2'b01;
    for (int e = 12; e <= 45; e++) begin
      stepEdge();
      expPeriph = (e < 37);
      expCpu    = (e < 41);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expCpu) begin
        testsFailed++;
        $display("[TB] FAIL simul_release edge %0d: got p=%b c=%b expected p=%b c=%b",
                 e, periph_reset, cpu_reset, expPeriph, expCpu);
      end
    end
  endtask

  task automatic test_async_abort();
    btn_in = 1'b0;
    repeat (11) stepEdge();
    btn_in = 1'b1;
    repeat (27) stepEdge();
    testsRun++;
    if (periph_reset !== 1'b0 || cpu_reset !== 1'b1 || reset_cause !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL abort_pre_rel_periph: got p=%b c=%b cause=%b expected p=0 c=1 cause=01",
               periph_reset, cpu_reset, reset_cause);
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if ({periph_reset, cpu_reset, reset_cause, seq_busy} !== 5'b11001) begin
      testsFailed++;
      $display("[TB] FAIL abort_immediate: got %b expected 11001", {periph_reset, cpu_reset, reset_cause, seq_busy});
    end
    repeat (3) stepEdge();
    reset = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      stepEdge();
      expPeriph = (e < 16);
      expCpu    = (e < 20);
      expBusy   = (e < 20);
      testsRun++;
      if (periph_reset !== expPeriph || cpu_reset !== expCpu || seq_busy !== expBusy || reset_cause !== 2'b00) begin
        testsFailed++;
        $display("[TB] FAIL abort_por_repeat edge %0d: got p=%b c=%b b=%b cause=%b expected p=%b c=%b b=%b cause=00",
                 e, periph_reset, cpu_reset, seq_busy, reset_cause, expPeriph, expCpu, expBusy);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expCause    = 2'b00;
    test_reset();
    test_glitch();
    test_button_press();
    test_sw_reset();
    test_simultaneous();
    test_async_abort();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller in the SoC top. It merges three reset sources into an ordered, glitch-free reset release for the peripheral and CPU domains: power-on/system reset, the debounced push button on `gpio_in[0]`, and an optional software request. Peripherals (GPIO, UART, bus fabric) leave reset before the CPU core, so the first instruction fetch always sees a quiescent bus. The block also records the cause of the last reset for software.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1000: consecutive stable synchronized cycles required to accept a new button level (≥2).
- `HOLD_CYCLES`, 16: cycles both resets stay asserted after the last reset source goes away (≥1).
- `STAGE_GAP`, 4: cycles between peripheral-reset release and CPU-reset release (≥1).
- `BTN_ACTIVE_LOW`, 1: 1 means `btn_in`=0 is "pressed".

Ports:
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `btn_in` in 1: raw asynchronous button pin (`gpio_in[0]`).
- `sw_reset_req` in 1: single-cycle software reset request (see Configuration).
- `periph_reset` out 1: active-high reset to peripherals and bus.
- `cpu_reset` out 1: active-high reset to the CPU core.
- `reset_cause` out 2: 00 POR, 01 button, 10 software, 11 reserved.
- `seq_busy` out 1: high in any state other than RUN.

## Operation
- Button path: 2-FF synchronizer, then debouncer. The debounced level flips only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any agreeing cycle clears the counter. The debounced level resets to "released". A press event is the debounced released→pressed transition, or a pressed level.
- FSM states: ASSERT, REL_PERIPH, RUN.
  - ASSERT: both resets high. The counter counts to `HOLD_CYCLES`. While the debounced button is pressed, the counter is held at 0. When the count completes, go to REL_PERIPH and drop `periph_reset`.
  - REL_PERIPH: `periph_reset` low, `cpu_reset` high. The counter counts to `STAGE_GAP`. When the count completes, go to RUN and drop `cpu_reset`.
  - RUN: both resets low, `seq_busy` low.
- A debounced press in any state goes to ASSERT with the counter cleared and `reset_cause`=01.
- An accepted `sw_reset_req` goes to ASSERT with `reset_cause`=10. It is accepted only in RUN and ignored in other states.
- If a press and `sw_reset_req` occur in the same cycle, the button wins and `reset_cause`=01.
- `reset_cause` updates only on entry to ASSERT and is stable otherwise.
- Counter widths are `$clog2(max+1)`. Counters saturate and never wrap.

## Timing
- Async `reset` high, effective immediately without a clock edge: state ASSERT, counter 0, `periph_reset`=1, `cpu_reset`=1, `reset_cause`=00, `seq_busy`=1, synchronizer and debouncer at "released".
- All outputs are registered. No combinational path runs from any input to any output.
- After `reset` falls with no other source active:
  - `periph_reset` falls on the `HOLD_CYCLES`-th rising edge.
  - `cpu_reset` falls `STAGE_GAP` edges later.
- Button press to resets high: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after the pin transition.
- Button release to `periph_reset` low: 2 + `DEBOUNCE_CYCLES` + `HOLD_CYCLES` cycles.
- Software request: resets high on the edge after the `sw_reset_req` cycle.
- `reset` asserted mid-sequence aborts the sequence immediately, and `reset_cause` returns to 00.

## Configuration
- `RSTSEQ_SWREQ_EN` defined: `sw_reset_req` is honoured as described above.
- `RSTSEQ_SWREQ_EN` undefined: `sw_reset_req` is ignored and has no loads, and `reset_cause` can never be 10. The port is still present so top-level wiring is unchanged.

## Structure
- Package `rstseq_pkg` holds:
  - the state enum (ASSERT, REL_PERIPH, RUN);
  - the cause constants `CAUSE_POR`, `CAUSE_BTN`, `CAUSE_SW`.
- Sub-module `btn_debounce` contains the synchronizer and debouncer. It has parameters `DEBOUNCE_CYCLES` and `BTN_ACTIVE_LOW`, and produces a level output `pressed`.
- The FSM and counters live in `reset_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `HOLD_CYCLES`=16, `STAGE_GAP`=4.
- POR: hold `reset` high for 5 cycles, then release → `periph_reset` falls at edge 16, `cpu_reset` falls at edge 20, `reset_cause`=00, `seq_busy`=0 after edge 20.
- Glitch rejection: in RUN, drive `btn_in` low for 5 cycles → resets stay low and `reset_cause` is unchanged.
- Button press: in RUN, drive `btn_in` low for 40 cycles → resets go high 11 cycles after the fall with `reset_cause`=01. After release, `periph_reset` falls 26 cycles later and `cpu_reset` falls 4 cycles after that.
- Software reset: pulse `sw_reset_req` for 1 cycle in RUN → both resets high on the next edge, `reset_cause`=10. A pulse during REL_PERIPH is ignored. With `RSTSEQ_SWREQ_EN` undefined, nothing happens.
- Simultaneous sources: debounced press and `sw_reset_req` in the same cycle → `reset_cause`=01.
- Async abort: assert `reset` during REL_PERIPH, with no clock edge → `periph_reset`=1 immediately and `reset_cause`=00. The full POR sequence then repeats.
